// File: rtl/h_scaler_ctrl_pkg.sv
// h_scaler_ctrl_pkg: shared widths, FSM encodings and config record for the scaler controllers
package h_scaler_ctrl_pkg;
  localparam int IMGS_WIDTH = 11;
  localparam int IMGO_WIDTH = 11;
  localparam int H_SCALER_DEC_WIDTH = 8;
  localparam int H_SCALER_INT_WIDTH = 3;
  localparam int STEP_WIDTH = H_SCALER_INT_WIDTH + H_SCALER_DEC_WIDTH;
  localparam logic [4:0] S_IDLE       = 5'b00001;
  localparam logic [4:0] S_WAIT_FRAME = 5'b00010;
  localparam logic [4:0] S_WAIT_DATA  = 5'b00100;
  localparam logic [4:0] S_ISSUE      = 5'b01000;
  localparam logic [4:0] S_WAIT_DONE  = 5'b10000;
  typedef struct packed {
    logic [IMGS_WIDTH-1:0]         src;
    logic [IMGO_WIDTH-1:0]         tgt;
    logic [IMGS_WIDTH-1:0]         height;
    logic [H_SCALER_INT_WIDTH-1:0] step_int;
    logic [H_SCALER_DEC_WIDTH-1:0] step_dec;
  } cfg_t;
endpackage

// File: rtl/h_scaler_ctrl_seq_divider.sv
// h_scaler_ctrl_seq_divider: restoring divider, one quotient bit per cycle, start restarts
module h_scaler_ctrl_seq_divider #(
  parameter int NW = 19,
  parameter int DW = 11,
  parameter int QW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic          ovf,
  output logic [QW-1:0] quotient
);
  localparam int CW = $clog2(QW + 1);
  logic [DW:0] rem, trial;
  logic [DW-1:0] d;
  logic [CW-1:0] cnt;
  logic run, fit;
  // quotient doubles as the dividend shift register: low bits go out as quotient bits come in
  assign trial = {rem[DW-1:0], quotient[QW-1]};
  assign fit = trial >= {1'b0, d};
  assign done = run && cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      d <= '0;
      quotient <= '0;
      cnt <= '0;
      run <= 1'b0;
      ovf <= 1'b0;
    end else if (start) begin
      rem <= (DW+1)'(dividend >> QW);
      d <= divisor;
      quotient <= dividend[QW-1:0];
      cnt <= CW'(QW);
      run <= 1'b1;
      ovf <= (dividend >> QW) >= NW'(divisor);
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else begin
        rem <= fit ? trial - {1'b0, d} : trial;
        quotient <= {quotient[QW-2:0], fit};
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: rtl/h_scaler_ctrl.sv
// h_scaler_ctrl: horizontal step computation, frame-boundary config apply and line-start sequencing
module h_scaler_ctrl
  import h_scaler_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IMGS_WIDTH-1:0]         cfg_src_width,
  input  logic [IMGO_WIDTH-1:0]         cfg_tgt_width,
  input  logic [IMGS_WIDTH-1:0]         cfg_src_height,
  input  logic                          cfg_update,
  input  logic                          frame_start,
  input  logic [IMGS_WIDTH:0]           fifo_level,
  input  logic                          out_line_req,
  input  logic                          line_done,
  output logic [IMGS_WIDTH-1:0]         source_width,
  output logic [IMGO_WIDTH-1:0]         vga_target_width,
  output logic [H_SCALER_INT_WIDTH-1:0] h_scaler_int,
  output logic [H_SCALER_DEC_WIDTH-1:0] h_scaler_dec,
  output logic                          line_end,
  output logic                          busy,
  output logic                          cfg_err,
  output logic [IMGS_WIDTH-1:0]         line_cnt
);
  logic [4:0] st, st_n;
  cfg_t pend, act;
  logic pend_valid, pend_frame, credit, div_done, ovf, bad;
  logic have_cfg, start_frame, go_issue, fin_line, restart, apply;
  logic [STEP_WIDTH-1:0] quot;
  h_scaler_ctrl_seq_divider #(
    .NW(IMGS_WIDTH + H_SCALER_DEC_WIDTH),
    .DW(IMGO_WIDTH),
    .QW(STEP_WIDTH)
  ) u_div (
    .clk(clk),
    .rst(rst),
    .start(cfg_update),
    .dividend({cfg_src_width, {H_SCALER_DEC_WIDTH{1'b0}}}),
    .divisor(cfg_tgt_width),
    .done(div_done),
    .ovf(ovf),
    .quotient(quot)
  );
  assign source_width = act.src;
  assign vga_target_width = act.tgt;
  assign h_scaler_int = act.step_int;
  assign h_scaler_dec = act.step_dec;
  assign line_end = st == S_ISSUE;
  assign busy = |(st & (S_WAIT_DATA | S_ISSUE | S_WAIT_DONE));
  // an applied config always has a nonzero height, so it marks that a valid config exists
  always_comb begin
    bad = pend.src == '0 || pend.tgt == '0 || pend.height == '0 || pend.src > pend.tgt || ovf;
    have_cfg = pend_valid || act.height != '0;
    start_frame = st == S_WAIT_FRAME && frame_start && have_cfg;
    go_issue = st == S_WAIT_DATA && fifo_level >= {1'b0, act.src} && credit;
    fin_line = st == S_WAIT_DONE && line_done;
    restart = fin_line && (pend_frame || frame_start);
    apply = (start_frame || restart) && pend_valid;
    st_n = st == S_IDLE ? (have_cfg ? S_WAIT_FRAME : S_IDLE)
         : start_frame ? S_WAIT_DATA
         : go_issue ? S_ISSUE
         : st == S_ISSUE ? S_WAIT_DONE
         : fin_line ? (restart || line_cnt < act.height ? S_WAIT_DATA : S_WAIT_FRAME)
         : st;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= S_IDLE;
      pend <= '0;
      act <= '{src: '0, tgt: '0, height: '0, step_int: H_SCALER_INT_WIDTH'(1), step_dec: '0};
      pend_valid <= 1'b0;
      pend_frame <= 1'b0;
      credit <= 1'b1;
      cfg_err <= 1'b0;
      line_cnt <= '0;
    end else begin
      st <= st_n;
      if (cfg_update) begin
        pend.src <= cfg_src_width;
        pend.tgt <= cfg_tgt_width;
        pend.height <= cfg_src_height;
        pend_valid <= 1'b0;
      end else if (div_done) begin
        cfg_err <= bad;
        pend_valid <= !bad;
        if (!bad) {pend.step_int, pend.step_dec} <= quot;
      end
      if (apply) act <= pend;
      credit <= out_line_req || start_frame || restart || (credit && !go_issue);
      line_cnt <= start_frame || restart ? '0 : go_issue ? line_cnt + 1'b1 : line_cnt;
      pend_frame <= !restart && (pend_frame || (frame_start && busy));
    end
endmodule
